// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider ratio controller: ratio width, minimum
// legal ratio and the sequencing state encoding.
package div_ctrl_pkg;

  localparam int RATIO_W = 4;
  localparam logic [RATIO_W-1:0] MIN_RATIO = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_QUIESCE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_SETTLE  = 3'd5
  } state_t;

  function automatic logic ratio_ok(input logic [RATIO_W-1:0] ratio);
    return (ratio >= MIN_RATIO);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; the pointer advances past the
// granted requester only when the grant is accepted.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NREQ-1:0]                     i_req,
  input  logic                                i_accept,
  output logic                                o_gnt_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_gnt_idx
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] r_ptr;
  int               w_sel;

  // Scan offsets from farthest to nearest so the first valid at/after the pointer wins.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_sel       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sel       = (int'(r_ptr) + k) % NREQ;
      o_gnt_valid = i_req[w_sel[IDX_W-1:0]] ? 1'b1 : o_gnt_valid;
      o_gnt_idx   = i_req[w_sel[IDX_W-1:0]] ? w_sel[IDX_W-1:0] : o_gnt_idx;
    end
  end

  // Pointer register, moved to grant+1 (wrapping) on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_accept && o_gnt_valid) begin
      r_ptr <= (o_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : o_gnt_idx + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Sequences glitch-safe ratio changes of the programmable clock divider:
// arbitrate, quiesce, hold in reset while loading, release, confirm lock.
module div_ratio_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DEFAULT_N   = 2,
  parameter int HOLD_CYC    = 3,
  parameter int QUIESCE_MAX = 32,
  parameter int SETTLE_MAX  = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [RATIO_W*NREQ-1:0] req_ratio,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    div_out,
  output logic [RATIO_W-1:0]      div_n,
  output logic                    div_rst_n,
  output logic                    busy,
  output logic                    locked,
  output logic                    err_pulse
);
  localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX0 = (QUIESCE_MAX > SETTLE_MAX) ? QUIESCE_MAX : SETTLE_MAX;
  localparam int CNT_MAX  = (CNT_MAX0 > HOLD_CYC) ? CNT_MAX0 : HOLD_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(QUIESCE_MAX - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(SETTLE_MAX - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_edges;
  logic                 r_d_q;
  logic                 r_d_prev;
  logic                 w_rise;
  logic [RATIO_W-1:0]   r_ratio;
  logic [RATIO_W-1:0]   r_div_n;
  logic                 r_div_rst_n;
  logic [NREQ-1:0]      r_req_ready;
  logic                 r_locked;
  logic                 r_err;
  logic                 r_busy;
  logic                 w_gnt_valid;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_accept;
  logic [RATIO_W-1:0]   w_sel_ratio;
  logic                 w_lock_set;
  logic                 w_lock_clr;
  logic                 w_err_set;

  assign w_rise   = r_d_q & ~r_d_prev;
  assign w_accept = (r_state == ST_IDLE) && w_gnt_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (req_valid),
    .i_accept    (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  // Ratio lane of the current grant.
  always_comb begin
    w_sel_ratio = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_ratio = (w_gnt_idx == IDX_W'(i)) ? req_ratio[RATIO_W*i +: RATIO_W] : w_sel_ratio;
    end
  end

  // Next-state logic and one-shot control flags.
  always_comb begin
    w_next_state = r_state;
    w_lock_set   = 1'b0;
    w_lock_clr   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) w_next_state = ST_ARB;
        else             w_next_state = ST_IDLE;
      end
      ST_ARB: begin
        if (!ratio_ok(r_ratio)) begin
          w_err_set    = 1'b1;
          w_next_state = ST_IDLE;
        end else if ((r_ratio == r_div_n) && r_locked) begin
          w_next_state = ST_IDLE;
        end else begin
          w_lock_clr   = 1'b1;
          w_next_state = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        // A stuck-high divider output must not block reprogramming forever.
        if (!r_d_q || (r_cnt == Q_LAST)) w_next_state = ST_HOLD;
        else                             w_next_state = ST_QUIESCE;
      end
      ST_HOLD: begin
        if (r_cnt == H_LAST) w_next_state = ST_RELEASE;
        else                 w_next_state = ST_HOLD;
      end
      ST_RELEASE: begin
        w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_rise && (r_edges == 2'd1)) begin
          w_lock_set   = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_cnt == S_LAST) begin
          w_err_set    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_SETTLE;
        end
      end
      default: begin
        w_next_state = ST_HOLD;
      end
    endcase
  end

  // State, per-state cycle counter, edge counter and divider-output sampling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_HOLD;
      r_cnt    <= '0;
      r_edges  <= 2'd0;
      r_d_q    <= 1'b0;
      r_d_prev <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_d_q    <= div_out;
      r_d_prev <= r_d_q;
      if (w_next_state != r_state) r_cnt <= '0;
      else if (r_cnt != CNT_SAT)   r_cnt <= r_cnt + 1'b1;
      else                         r_cnt <= r_cnt;
      if (r_state == ST_RELEASE)                          r_edges <= 2'd0;
      else if ((r_state == ST_SETTLE) && w_rise && (r_edges != 2'd3)) r_edges <= r_edges + 2'd1;
      else                                                r_edges <= r_edges;
    end
  end

  // Registered outputs; div_n only moves on entry to HOLD, with the divider in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ratio     <= RATIO_W'(DEFAULT_N);
      r_div_n     <= RATIO_W'(DEFAULT_N);
      r_div_rst_n <= 1'b0;
      r_req_ready <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_ratio     <= w_accept ? w_sel_ratio : r_ratio;
      r_req_ready <= w_accept ? (NREQ'(1'b1) << w_gnt_idx) : '0;
      if ((r_state == ST_QUIESCE) && (w_next_state == ST_HOLD)) r_div_n <= r_ratio;
      else                                                       r_div_n <= r_div_n;
      r_div_rst_n <= (w_next_state != ST_HOLD);
      if (w_lock_clr)      r_locked <= 1'b0;
      else if (w_lock_set) r_locked <= 1'b1;
      else                 r_locked <= r_locked;
      r_err       <= w_err_set;
      r_busy      <= (w_next_state != ST_IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign div_n     = r_div_n;
  assign div_rst_n = r_div_rst_n;
  assign busy      = r_busy;
  assign locked    = r_locked;
  assign err_pulse = r_err;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Randomized and directed bench for div_ratio_ctrl with a divider model and a
// transaction-level reference model of ratio, lock, error and hold activity.
module tb_div_ratio_ctrl;
  localparam int NREQ        = 2;
  localparam int DEFAULT_N   = 2;
  localparam int HOLD_CYC    = 3;
  localparam int QUIESCE_MAX = 32;
  localparam int SETTLE_MAX  = 64;
  localparam int BOUND       = 400;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0] req_valid;
  logic [4*NREQ-1:0] req_ratio;
  logic [NREQ-1:0] req_ready;
  logic            div_out;
  logic [3:0]      div_n;
  logic            div_rst_n;
  logic            busy;
  logic            locked;
  logic            err_pulse;

  div_ratio_ctrl #(
    .NREQ(NREQ), .DEFAULT_N(DEFAULT_N), .HOLD_CYC(HOLD_CYC),
    .QUIESCE_MAX(QUIESCE_MAX), .SETTLE_MAX(SETTLE_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ratio(req_ratio),
    .req_ready(req_ready), .div_out(div_out), .div_n(div_n), .div_rst_n(div_rst_n),
    .busy(busy), .locked(locked), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Divider model: 0 = running divider, 1 = output stuck low, 2 = stuck high.
  int   mode = 0;
  int   dcnt = 0;
  logic dmod = 1'b0;

  function automatic int nxt_cnt(input int c, input logic [3:0] n);
    return (c >= int'(n) - 1) ? 0 : c + 1;
  endfunction

  always @(posedge clk) begin
    if (!div_rst_n) begin
      dcnt <= 0;
      dmod <= 1'b0;
    end else begin
      dcnt <= nxt_cnt(dcnt, div_n);
      dmod <= (nxt_cnt(dcnt, div_n) >= int'(div_n) / 2);
    end
  end

  assign div_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : dmod;

  int checks = 0;
  int errors = 0;
  int tcount = 0;
  int rst_low, err_cnt;
  logic [NREQ-1:0] seen_ready;
  logic prev_rst = 1'b0;
  logic [3:0] prev_div_n = 4'd2;
  logic [3:0] hold_n;

  // Reference model state.
  logic [3:0] m_div_n;
  bit         m_locked;
  int         m_ptr, exp_rst, exp_err;
  int         t0, t_ready, t_hold, t_rel, t_err, t_divn;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tcount++;
    seen_ready = req_ready;
    if (req_ready != '0) check_val("ready_onehot", $countones(req_ready), 1);
    if (div_n != prev_div_n) check_val("div_n_moves_only_in_reset", div_rst_n, 0);
    if (!div_rst_n) rst_low++;
    if (!div_rst_n && prev_rst) hold_n = div_n;
    if (err_pulse) err_cnt++;
    prev_rst   = div_rst_n;
    prev_div_n = div_n;
  endtask

  task automatic apply_model(input logic [3:0] r);
    if (r < 4'd2) begin
      exp_err++;
    end else if (!(r == m_div_n && m_locked)) begin
      exp_rst += HOLD_CYC;
      m_div_n  = r;
      if (mode == 0) m_locked = 1'b1;
      else begin m_locked = 1'b0; exp_err++; end
    end
  endtask

  task automatic compare_state(input string tag);
    check_val({tag, "_div_n"}, div_n, m_div_n);
    check_val({tag, "_locked"}, locked, m_locked);
    check_val({tag, "_rst_low"}, rst_low, exp_rst);
    check_val({tag, "_err"}, err_cnt, exp_err);
    check_val({tag, "_hold_n"}, hold_n, m_div_n);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < BOUND);
    check_val({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n   = 1'b0;
    req_valid = '0;
    req_ratio = '0;
    mode      = 0;
    tick(); tick();
    check_val("rst_div_n", div_n, DEFAULT_N);
    check_val("rst_div_rst_n", div_rst_n, 0);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_err", err_pulse, 0);
    check_val("rst_busy", busy, 1);
    reset_n = 1'b1;
    // The cycle in which reset deasserts is the first hold cycle.
    rst_low  = 1;
    err_cnt  = 0;
    exp_rst  = HOLD_CYC;
    exp_err  = 0;
    m_div_n  = 4'(DEFAULT_N);
    m_locked = 1'b1;
    m_ptr    = 0;
    hold_n   = 4'(DEFAULT_N);
    wait_idle(tag);
    compare_state(tag);
  endtask

  // Raise the requesters in mask and serve them in the model's round-robin order.
  task automatic serve(input string tag, input logic [NREQ-1:0] mask,
                       input logic [3:0] r0, input logic [3:0] r1);
    logic [NREQ-1:0] pending;
    int g, n;
    req_ratio = {r1, r0};
    req_valid = mask;
    pending   = mask;
    while (pending != '0) begin
      g = m_ptr;
      while (!pending[g]) g = (g + 1) % NREQ;
      n = 0;
      do begin tick(); n++; end while (seen_ready == '0 && n < BOUND);
      check_val({tag, "_grant"}, seen_ready, 1 << g);
      req_valid[g] = 1'b0;
      pending[g]   = 1'b0;
      m_ptr        = (g + 1) % NREQ;
      apply_model((g == 0) ? r0 : r1);
      wait_idle(tag);
      compare_state(tag);
    end
  endtask

  // Single request with timestamps of ready, hold entry/exit, error and new div_n.
  task automatic timed_req(input string tag, input int idx, input logic [3:0] r);
    int n = 0;
    req_ratio[4*idx +: 4] = r;
    req_valid[idx] = 1'b1;
    t0 = tcount; t_ready = -1; t_hold = -1; t_rel = -1; t_err = -1; t_divn = -1;
    while (n < BOUND) begin
      tick(); n++;
      if (seen_ready[idx] && t_ready < 0) begin t_ready = tcount; req_valid[idx] = 1'b0; end
      if (!div_rst_n && t_ready >= 0 && t_hold < 0) t_hold = tcount;
      if (div_rst_n && t_hold >= 0 && t_rel < 0) t_rel = tcount;
      if (err_pulse && t_err < 0) t_err = tcount;
      if (div_n == r && t_divn < 0) t_divn = tcount;
      if (t_ready >= 0 && busy == 1'b0) break;
    end
    check_val({tag, "_done"}, busy, 0);
    m_ptr = (idx + 1) % NREQ;
    apply_model(r);
    compare_state(tag);
  endtask

  function automatic logic [3:0] pick_ratio();
    if ($urandom_range(0, 3) == 0) return m_div_n;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [3:0] rr;
    int n;
    do_reset("init");

    serve("dual", 2'b11, 4'd7, 4'd3);
    serve("dual2", 2'b11, 4'd9, 4'd4);
    serve("r5", 2'b01, 4'd5, 4'd0);
    serve("reject", 2'b10, 4'd0, 4'd1);
    serve("same", 2'b01, 4'd5, 4'd0);

    // Output stuck high: quiesce is forced, then settle times out.
    mode = 2;
    tick(); tick(); tick();
    timed_req("stuck1", 0, 4'd4);
    check_val("quiesce_force_cycles", t_hold - t_ready, 1 + QUIESCE_MAX);
    check_val("settle_timeout_cycles", t_err - t_rel, 1 + SETTLE_MAX);

    // Output stuck low: minimum latency, then settle timeout.
    mode = 1;
    tick(); tick(); tick();
    timed_req("stuck0", 1, 4'd6);
    check_val("min_latency", t_divn - t0, 3);
    check_val("settle_timeout0", t_err - t_rel, 1 + SETTLE_MAX);

    mode = 0;
    for (int i = 0; i < 16; i++) begin
      serve("rand", 2'($urandom_range(1, 3)), pick_ratio(), pick_ratio());
    end

    // Reset in the middle of a hold.
    rr = (m_div_n == 4'd9) ? 4'd10 : 4'd9;
    req_ratio[3:0] = rr;
    req_valid[0]   = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      if (seen_ready[0]) req_valid[0] = 1'b0;
    end while (div_rst_n !== 1'b0 && n < BOUND);
    check_val("midhold_reached", div_rst_n, 0);
    check_val("midhold_div_n", div_n, rr);
    reset_n = 1'b0;
    #1;
    check_val("async_div_n", div_n, DEFAULT_N);
    check_val("async_ready", req_ready, 0);
    check_val("async_locked", locked, 0);
    do_reset("reinit");
    serve("post", 2'b11, 4'd8, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
